// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes
// and the host-to-device frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;

  // {stop, odd parity, data, start}; shifted out LSB first.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
// Shared between the host transmitter and the scancode receiver.
module ps2_line_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset to the idle-high bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      prev_q <= sync_q[1];
    end
  end

  assign sync_o = sync_q[1];
  assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, requests to send,
// shifts one framed byte out on device clock edges and checks the acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned RQ_CYCLES      = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned     CNT_W   = 17;
  localparam logic [CNT_W-1:0] RQ_LAST = CNT_W'(RQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  ps2_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic             data_oe_q, data_oe_d;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;
  logic watchdog, timeout;

  ps2_line_sync u_clk_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .line_i (ps2_clock),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .line_i (ps2_data),
    .sync_o (data_sync),
    .fall_o (data_fall_unused)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
    end
  end

  // NOTE: every next-state and output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_oe_d    = data_oe_q;
    cnt_d        = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    tx_ready     = 1'b0;
    busy         = 1'b1;
    ps2_clock_oe = 1'b0;
    ps2_data_oe  = 1'b0;
    done         = 1'b0;
    error        = 1'b0;

    // Our own clock pull-down during INHIBIT also shows up as a fall, so the
    // watchdog only tracks device-driven states.
    watchdog = (state_q == REQ) || (state_q == BITS) ||
               (state_q == ACK) || (state_q == WAIT_IDLE);
    timeout  = watchdog && (cnt_q >= TIMEOUT);

    case (state_q)
      IDLE: begin
        tx_ready  = 1'b1;
        busy      = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d = ps2_tx_frame(tx_data);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clock_oe = 1'b1;
        if (cnt_q >= RQ_LAST) begin
          ps2_data_oe = ~shift_q[0];
          state_d     = REQ;
        end
      end
      REQ: begin
        ps2_data_oe = ~shift_q[0];
        if (clk_fall) begin
          bit_cnt_d = '0;
          data_oe_d = ~shift_q[0];
          state_d   = BITS;
        end
      end
      BITS: begin
        ps2_data_oe = data_oe_q;
        if (clk_fall) begin
          shift_d   = {1'b1, shift_q[9:1]};
          data_oe_d = ~shift_q[1];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            error   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      ps2_clock_oe = 1'b0;
      ps2_data_oe  = 1'b0;
      done         = 1'b0;
      error        = 1'b1;
      data_oe_d    = 1'b0;
      state_d      = IDLE;
    end

    if ((state_d != state_q) || (clk_fall && watchdog)) begin
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard that clocks
// the frame in, samples bits on rising edges and optionally acknowledges.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int RQ = 50;
  localparam int TO = 2000;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clock_oe, ps2_data_oe, tx_ready, busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock_line, ps2_data_line;

  assign ps2_clock_line = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_line  = ~(ps2_data_oe | dev_data_low);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;

  ps2_host_tx #(
    .RQ_CYCLES      (RQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .ps2_clock    (ps2_clock_line),
    .ps2_data     (ps2_data_line),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if (done === 1'b1 && error === 1'b1) both_seen = 1'b1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 80000", cyc);
    $fatal(1, "watchdog expired");
  end

  // Wire-level view of a frame as the keyboard samples it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] expected_wire(input logic [7:0] b);
    logic [10:0] w;
    w[0] = 1'b0;
    for (int i = 0; i < 8; i++) w[i+1] = (b >> i) & 8'h01;
    w[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    w[10] = 1'b1;
    return w;
  endfunction

  task automatic dev_frame(input int n_clk, input bit ack, input int half,
                           output logic [10:0] seen, output bit ok);
    int t;
    seen = '0;
    ok   = 1'b0;
    t    = 0;
    while (!(ps2_clock_line === 1'b1 && ps2_data_line === 1'b0) && t < RQ + 200) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= RQ + 200) return;
    repeat (half) @(negedge clk_in);
    for (int i = 0; i < n_clk; i++) begin
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk_in);
      dev_clk_low = 1'b0;
      if (i < 11) seen[i] = ps2_data_line;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (i == 11) dev_data_low = 1'b0;
      if (i < n_clk - 1) repeat (half) @(negedge clk_in);
    end
    ok = 1'b1;
  endtask

  // Requests a transfer and checks the inhibit/request timing up to clock release.
  task automatic accept_inhibit(input logic [7:0] b, input bit keep, input logic [7:0] b_next,
                                output bit ok);
    ok       = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_in);
      if (busy === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept %h: busy got %b expected 1 within 20 cycles", b, busy);
      tx_valid = 1'b0;
      return;
    end
    if (keep) tx_data = b_next;
    else tx_valid = 1'b0;
    checks++;
    if (ps2_clock_oe !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL inhibit_start: clock_oe/tx_ready got %b%b expected 10", ps2_clock_oe, tx_ready);
    end
    repeat (RQ - 2) @(negedge clk_in);
    checks++;
    if ({ps2_clock_oe, ps2_data_oe} !== 2'b10) begin
      errors++;
      $display("FAIL inhibit_hold: clock_oe,data_oe got %b%b expected 10", ps2_clock_oe, ps2_data_oe);
    end
    @(negedge clk_in);
    checks++;
    if ({ps2_clock_oe, ps2_data_oe} !== 2'b11) begin
      errors++;
      $display("FAIL start_bit: clock_oe,data_oe got %b%b expected 11", ps2_clock_oe, ps2_data_oe);
    end
    @(negedge clk_in);
    checks++;
    if ({ps2_clock_oe, ps2_data_oe} !== 2'b01) begin
      errors++;
      $display("FAIL clock_release: clock_oe,data_oe got %b%b expected 01", ps2_clock_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) begin
      errors++;
      $display("FAIL reset_oe: got %b%b expected 00", ps2_clock_oe, ps2_data_oe);
    end
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready_busy: got %b%b expected 10", tx_ready, busy);
    end
    checks++;
    if ({done, error} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pulses: got %b%b expected 00", done, error);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_send(input logic [7:0] b, input int half, input bit ack);
    logic [10:0] seen, exp_w;
    bit ok, found;
    int d0, e0;
    d0    = done_cnt;
    e0    = err_cnt;
    exp_w = expected_wire(b);
    found = 1'b0;
    accept_inhibit(b, 1'b0, 8'h00, ok);
    if (!ok) return;
    dev_frame(12, ack, half, seen, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dev_request %h: request got 0 expected 1", b);
    end
    checks++;
    if (seen !== exp_w) begin
      errors++;
      $display("FAIL frame %h: wire got %b expected %b", b, seen, exp_w);
    end
    if (ack) begin
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge clk_in);
        if (done === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL done_pulse %h: got 0 expected 1 within 50 cycles", b);
      end
      @(negedge clk_in);
    end else begin
      repeat (3) @(negedge clk_in);
    end
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL ready_after %h: tx_ready,busy got %b%b expected 10", b, tx_ready, busy);
    end
    checks++;
    if (done_cnt !== d0 + (ack ? 1 : 0)) begin
      errors++;
      $display("FAIL done_count %h: got %0d expected %0d", b, done_cnt - d0, ack ? 1 : 0);
    end
    checks++;
    if (err_cnt !== e0 + (ack ? 0 : 1)) begin
      errors++;
      $display("FAIL error_count %h: got %0d expected %0d", b, err_cnt - e0, ack ? 0 : 1);
    end
  endtask

  task automatic test_timeout(input logic [7:0] b);
    bit ok, found;
    int rel, err_at, d0;
    logic [1:0] oe_at;
    d0     = done_cnt;
    found  = 1'b0;
    err_at = 0;
    oe_at  = 2'bxx;
    accept_inhibit(b, 1'b0, 8'h00, ok);
    if (!ok) return;
    rel = cyc;
    for (int i = 0; i < TO + 50 && !found; i++) begin
      @(negedge clk_in);
      if (error === 1'b1) begin
        found  = 1'b1;
        err_at = cyc;
        oe_at  = {ps2_clock_oe, ps2_data_oe};
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout_pulse: got none expected error within %0d cycles", TO + 50);
    end
    checks++;
    if (err_at - rel !== TO) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", err_at - rel, TO);
    end
    checks++;
    if (oe_at !== 2'b00) begin
      errors++;
      $display("FAIL timeout_oe: got %b expected 00", oe_at);
    end
    @(negedge clk_in);
    checks++;
    if ({tx_ready, busy} !== 2'b10 || done_cnt !== d0) begin
      errors++;
      $display("FAIL timeout_idle: tx_ready,busy got %b%b dones %0d expected 10 dones 0",
               tx_ready, busy, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back(input int half);
    logic [10:0] seen, exp_a, exp_b;
    bit ok, found;
    int d0, e0;
    d0    = done_cnt;
    e0    = err_cnt;
    exp_a = expected_wire(PS2_CMD_SET_LED);
    exp_b = expected_wire(8'h55);
    accept_inhibit(PS2_CMD_SET_LED, 1'b1, 8'h55, ok);
    if (!ok) return;
    dev_frame(12, 1'b1, half, seen, ok);
    checks++;
    if (!ok || seen !== exp_a) begin
      errors++;
      $display("FAIL b2b_first: wire got %b expected %b", seen, exp_a);
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_in);
      if (done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_done1: got 0 expected 1 within 50 cycles");
    end
    @(negedge clk_in);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got %b expected 1", tx_ready);
    end
    @(negedge clk_in);
    checks++;
    if ({busy, ps2_clock_oe} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_accept: busy,clock_oe got %b%b expected 11", busy, ps2_clock_oe);
    end
    tx_valid = 1'b0;
    dev_frame(12, 1'b1, half, seen, ok);
    checks++;
    if (!ok || seen !== exp_b) begin
      errors++;
      $display("FAIL b2b_second: wire got %b expected %b", seen, exp_b);
    end
    checks++;
    if (seen[9] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_parity: got %b expected 1", seen[9]);
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_in);
      if (done === 1'b1) found = 1'b1;
    end
    @(negedge clk_in);
    checks++;
    if (done_cnt !== d0 + 2 || err_cnt !== e0) begin
      errors++;
      $display("FAIL b2b_counts: dones %0d errors %0d expected 2 and 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_bits(input logic [7:0] b);
    logic [10:0] seen, exp_w;
    bit ok;
    int d0, e0;
    d0    = done_cnt;
    e0    = err_cnt;
    exp_w = expected_wire(b);
    accept_inhibit(b, 1'b0, 8'h00, ok);
    if (!ok) return;
    dev_frame(5, 1'b0, 30, seen, ok);
    repeat (5) @(negedge clk_in);
    checks++;
    if (!ok || busy !== 1'b1 || seen[4:0] !== exp_w[4:0]) begin
      errors++;
      $display("FAIL midbits_progress: busy %b wire %b expected busy 1 wire %b", busy, seen[4:0], exp_w[4:0]);
    end
    reset = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({ps2_clock_oe, ps2_data_oe, busy, tx_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midbits_reset: clock_oe,data_oe,busy,tx_ready got %b%b%b%b expected 0001",
               ps2_clock_oe, ps2_data_oe, busy, tx_ready);
    end
    checks++;
    if ({done, error} !== 2'b00) begin
      errors++;
      $display("FAIL midbits_pulses: got %b%b expected 00", done, error);
    end
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    checks++;
    if (done_cnt !== d0 || err_cnt !== e0) begin
      errors++;
      $display("FAIL midbits_counts: dones %0d errors %0d expected 0 and 0", done_cnt - d0, err_cnt - e0);
    end
    test_send(PS2_CMD_ENABLE, 35, 1'b1);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      test_send(8'($urandom_range(0, 255)), int'($urandom_range(20, 60)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_send(PS2_CMD_SET_LED, 50, 1'b1);
    test_send(PS2_CMD_ENABLE, 40, 1'b1);
    test_timeout(PS2_CMD_RESET);
    test_send(8'h00, 30, 1'b0);
    test_back_to_back(45);
    test_reset_mid_bits(8'hA5);
    test_random(4);
    checks++;
    if (both_seen !== 1'b0) begin
      errors++;
      $display("FAIL pulse_overlap: done and error together got 1 expected 0");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per handshake to the keyboard, for example 0xED for set LEDs, 0xF4 for enable, or 0xFF for reset. It drives the open-drain clock and data lines through output-enable pins and reports completion or error. It sits beside the existing PS/2 scancode receiver on the same two wires. While `busy` is high, the keyboard controller must ignore received scancodes.

## Interface
Parameters:
- `RQ_CYCLES`, default 5000: clock-inhibit hold time in `clk_in` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 100000: maximum `clk_in` cycles allowed between device clock falling edges (2 ms).

Ports:
- `clk_in` input 1: system clock, 50 MHz.
- `reset` input 1: synchronous, active-high reset.
- `ps2_clock` input 1: raw PS/2 clock line level.
- `ps2_data` input 1: raw PS/2 data line level.
- `ps2_clock_oe` output 1: 1 = pull the clock line low, 0 = release it.
- `ps2_data_oe` output 1: 1 = pull the data line low, 0 = release it.
- `tx_data` input 8: command byte to send.
- `tx_valid` input 1: request to send `tx_data`.
- `tx_ready` output 1: high only in IDLE; a transfer is accepted when `tx_valid && tx_ready`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the device acknowledges the byte.
- `error` output 1: one-cycle pulse on timeout or missing acknowledge.

## Operation
- `ps2_clock` and `ps2_data` each pass through a 2-flop synchronizer. A device clock falling edge (`fall`) is detected as synchronized previous value 1 and current value 0.
- On acceptance, the frame {stop=1, parity, tx_data[7:0], start=0} is latched into a 10-bit shift register, sent LSB first. Parity is odd: `~^tx_data`.
- State machine:
  - **IDLE**: both `oe` low, `tx_ready`=1. On accept, go to INHIBIT and clear the counter.
  - **INHIBIT**: `ps2_clock_oe`=1 for `RQ_CYCLES` cycles. In the last cycle, set `ps2_data_oe`=1 (start bit) and go to REQ.
  - **REQ**: `ps2_clock_oe`=0, `ps2_data_oe`=1. Wait for `fall`, then go to BITS with `bit_cnt`=0.
  - **BITS**: on each `fall`, shift and set `ps2_data_oe` = ~(next bit), in order d0..d7, parity, stop. At the 10th `fall` (stop bit presented), `ps2_data_oe`=0; go to ACK.
  - **ACK**: on the next `fall`, sample synchronized data. If 0, go to WAIT_IDLE; if 1, pulse `error` and go to IDLE.
  - **WAIT_IDLE**: once synchronized clock and data are both 1, pulse `done` and go to IDLE.
- Timeout:
  - The counter resets on every `fall` and on every state entry.
  - In REQ, BITS, ACK or WAIT_IDLE, reaching `TIMEOUT_CYCLES` causes: both `oe` low, `error` pulse, go to IDLE.
- `tx_valid` while busy is ignored and not queued. The requester must hold `tx_valid` until it sees `tx_ready`.
- Reset in any state: go to IDLE, both `oe` low, counters cleared, no `done` or `error` pulse.

## Timing
- Reset values: `ps2_clock_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `busy`=0, `done`=0, `error`=0.
- Accept at cycle N: `ps2_clock_oe`=1 and `busy`=1 at cycle N+1.
- Clock release happens `RQ_CYCLES`+1 cycles after accept. Data goes low 1 cycle before clock release.
- Line changes in response to a device edge take effect 3 cycles after the raw line falls (2 synchronizer + 1 register). This is well inside the device low half-period of at least 30 µs.
- `done` and `error` are never asserted in the same cycle. `tx_ready` returns to 1 in the cycle after the pulse.
- Counters:
  - Cycle counter is 17 bits wide, saturating use only.
  - `bit_cnt` is 4 bits wide, values 0..10.

## Structure
- Shared package `ps2_pkg`:
  - state enum `ps2_tx_state_t` (IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE);
  - command constants `PS2_CMD_SET_LED`=8'hED, `PS2_CMD_ENABLE`=8'hF4, `PS2_CMD_RESET`=8'hFF;
  - response constants `PS2_ACK`=8'hFA, `PS2_BAT_OK`=8'hAA.
- One sub-module, `ps2_line_sync`: a 2-flop synchronizer plus falling-edge detector, instantiated once per line. It is reusable by the receiver.
- Top-level tri-state: `inout = oe ? 1'b0 : 1'bz`, placed outside this block.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz:
  - data seen on rising edges = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - model acks low → one `done` pulse, `tx_ready` back to 1.
- Send 0xF4 → parity bit 0 on the wire; `done` pulse.
- Send 0xFF, then the device model never clocks → `error` pulse exactly `TIMEOUT_CYCLES` after clock release; both `oe` low.
- Send 0x00 while the model omits the ack (data stays 1 on the 11th fall) → `error`, no `done`.
- `tx_valid` with 0x55 asserted during an 0xED transfer → ignored. After `done`, a held `tx_valid` is accepted and 0x55 is sent with parity 1.
- `reset` asserted mid-BITS (after 4 bits) → next cycle both `oe`=0, `busy`=0, no pulses. A new 0xF4 transfer then completes normally.
